ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Two-requester front end for the 16-bit-word, 13-bit-address single-port program/data RAM.
- Sits directly upstream of the RAM and is its only driver.
- Multiplexes the CPU instruction-fetch port and the CPU data port onto one RAM access per cycle.
- Tracks the RAM's one-cycle registered read latency, returns read data to the correct requester with a valid strobe, and bounds instruction-fetch starvation.

Parameters:
- ADDR_W, 13, word address width; matches the RAM address input.
- DATA_W, 16, data word width.
- MAX_DATA_RUN, 4, maximum consecutive data-port grants while an instruction request is pending (range 1..15).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  synchronous reset, active-high.
- i_req  in  1  instruction fetch request; held until granted.
- i_addr  in  ADDR_W  fetch word address.
- i_gnt  out  1  fetch accepted this cycle (combinational).
- i_rvalid  out  1  fetch data valid this cycle.
- i_rdata  out  DATA_W  fetch data; holds last returned value.
- d_req  in  1  data request; held until granted.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  data read data valid this cycle (reads only).
- d_rdata  out  DATA_W  data read result; holds last returned value.
- mem_addr  out  ADDR_W  to RAM addr.
- mem_data_in  out  DATA_W  to RAM data_in.
- mem_data_out  in  DATA_W  from RAM data_out; valid one cycle after a read access.
- mem_we  out  1  to RAM we.
- mem_re  out  1  to RAM re.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0, run counter=0, rr pointer=0.
- Combinational outputs during rst: gnt=0, mem_we=0, mem_re=0.
- Grants: at most one per cycle.
  - i_gnt and d_gnt are combinational from req plus arbitration state.
  - A requester holding req without gnt must keep addr/we/wdata stable.
- Arbitration without the optional feature:
  - Data port has priority.
  - Exception: if i_req=1 and the run counter equals MAX_DATA_RUN, the instruction port wins.
  - Run counter increments on each d_gnt while i_req=1.
  - Run counter clears on any i_gnt, or on any cycle with i_req=0.
  - Run counter saturates at MAX_DATA_RUN.
- Memory drive:
  - mem_addr = granted port's addr. With no grant, mem_addr = d_addr (don't-care, but stable).
  - mem_data_in = d_wdata always.
  - mem_we = d_gnt & d_we.
  - mem_re = (i_gnt) | (d_gnt & ~d_we).
- Read latency: exactly 1 cycle.
  - Registered owner tag: fetch read, data read, or none.
  - Cycle N+1 after an i_gnt: i_rvalid=1 and i_rdata=mem_data_out, captured into the hold register.
  - Same rule for a data read: d_rvalid and d_rdata.
  - rvalid is high for exactly one cycle; at other times rdata outputs the hold register.
- Data writes: d_gnt is the only acknowledgement; no d_rvalid. Write takes effect at the grant edge.
- Back-to-back accesses: full throughput, one access per cycle.
  - A new grant may occur in the same cycle as the previous access's rvalid.
- Read-after-write to the same address, on consecutive grants: returns the new data (RAM write-first not required; write completes at the prior edge).
- Reset mid-operation: a pending owner tag is cleared; no rvalid is emitted in the cycle after rst deasserts.
- Requests are ignored during rst.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - On contention (both req=1), grant alternates.
  - rr pointer toggles to the other port after each contended grant.
  - An uncontended grant sets the pointer to the other port.
  - The run counter and MAX_DATA_RUN are unused; the counter is not synthesised.
- Undefined: data priority with the MAX_DATA_RUN starvation bound as described above.

Test Plan:
- Reset: assert rst 2 cycles with both req=1 -> no gnt, mem_we=0, mem_re=0; after release, rvalids stay 0 and rdata=0x0000.
- Single fetch: RAM preloaded with 0x1234 at 0x0005; i_req at 0x0005 for one cycle -> i_gnt same cycle; next cycle i_rvalid=1, i_rdata=0x1234; rdata still 0x1234 two cycles later with i_rvalid=0.
- Write then read: d_we=1, addr 0x1FFF, wdata 0xBEEF; next cycle d read 0x1FFF -> d_rvalid the following cycle with d_rdata=0xBEEF; mem_we high only during the write grant.
- Starvation bound (macro off, MAX_DATA_RUN=4): d_req and i_req held continuously -> grant sequence D,D,D,D,I,D,D,D,D,I; each rvalid goes to the correct port one cycle after its grant.
- Round robin (ARB_ROUND_ROBIN_EN defined): both req held 6 cycles -> alternating D,I,D,I,D,I starting with the port selected by the rr pointer (D after reset).
- Reset mid-read: i_gnt in cycle N, rst in cycle N+1 -> i_rvalid=0 in N+1 and N+2; i_rdata=0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Two-requester front end (instruction fetch + data port) for the
//            single-port 16-bit program/data RAM. Grants one RAM access per
//            cycle, tracks the RAM's one-cycle read latency with an owner tag
//            and steers returned read data to the requester that issued it.
// Options  : ARB_ROUND_ROBIN_EN - alternate grants on contention instead of
//            data-priority with a MAX_DATA_RUN fetch starvation bound.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 16,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // RAM side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_we,
  output logic              mem_re
);

  // Who owns the RAM read data that appears on mem_data_out this cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

`ifdef ARB_ROUND_ROBIN_EN
  // ------------------------------------------------------------------------
  // Round-robin arbitration: rr_q names the port that wins the next
  // contended cycle (0 = data, 1 = fetch). Whichever port is granted, the
  // pointer moves to the other one, so an idle port gets first turn later.
  // ------------------------------------------------------------------------
  logic rr_q, rr_d;

  // Grant selection and next pointer value.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    rr_d  = rr_q;
    if (!rst) begin
      if (i_req && d_req) begin
        i_gnt = rr_q;
        d_gnt = ~rr_q;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
      if (d_gnt) begin
        rr_d = 1'b1;
      end else if (i_gnt) begin
        rr_d = 1'b0;
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // ------------------------------------------------------------------------
  // Data-priority arbitration with a fetch starvation bound: run_q counts
  // consecutive data grants taken while a fetch is waiting. Once it reaches
  // MAX_DATA_RUN the fetch port wins, which clears the count.
  // ------------------------------------------------------------------------
  localparam logic [3:0] C_MAX_RUN = 4'(MAX_DATA_RUN);

  logic [3:0] run_q, run_d;
  logic       run_limit;

  assign run_limit = (run_q == C_MAX_RUN);

  // Grant selection and next run-count value.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    run_d = run_q;
    if (!rst) begin
      if (d_req && !(i_req && run_limit)) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
      if (i_gnt || !i_req) begin
        run_d = 4'd0;
      end else if (d_gnt && !run_limit) begin
        run_d = run_q + 4'd1;
      end
    end
  end

  // Data run counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 4'd0;
    end else begin
      run_q <= run_d;
    end
  end
`endif

  // RAM drive: write data always comes from the data port; the address
  // defaults to d_addr when nothing is granted so the bus stays quiet.
  always_comb begin
    mem_addr    = i_gnt ? i_addr : d_addr;
    mem_data_in = d_wdata;
    mem_we      = d_gnt & d_we;
    mem_re      = i_gnt | (d_gnt & ~d_we);
  end

  // Owner tag for the read issued this cycle; writes leave no tag.
  always_comb begin
    owner_d = OWN_NONE;
    if (i_gnt) begin
      owner_d = OWN_FETCH;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_DATA;
    end
  end

  // Valid strobes follow the tag; gating with rst drops a read whose
  // return cycle coincides with reset.
  always_comb begin
    i_rvalid  = (owner_q == OWN_FETCH) && !rst;
    d_rvalid  = (owner_q == OWN_DATA)  && !rst;
    i_rdata   = i_rvalid ? mem_data_out : i_rdata_q;
    d_rdata   = d_rvalid ? mem_data_out : d_rdata_q;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
  end

  // Owner tag and read-data hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      owner_q   <= owner_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Directed self-checking bench for ram_port_arbiter with a simple
//            behavioural single-port RAM (registered read, write at edge).
// Options  : ARB_ROUND_ROBIN_EN selects the alternating-grant expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_we;
  logic              mem_re;

  int n_vec = 0;
  int n_err = 0;

  ram_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_DATA_RUN(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_gnt       (i_gnt),
    .i_rvalid    (i_rvalid),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out),
    .mem_we      (mem_we),
    .mem_re      (mem_re)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: write at the edge, registered read data next cycle.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_rd_q;

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = '0;
    ram[13'h0005] = 16'h1234;
    ram[13'h0100] = 16'hA5A5;
    ram[13'h0200] = 16'h5A5A;
    ram_rd_q      = '0;
  end

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_data_in;
    if (mem_re) ram_rd_q <= ram[mem_addr];
  end
  assign mem_data_out = ram_rd_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  localparam int NPAT = 6;
  bit pat_i [NPAT] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
  localparam int NPAT = 10;
  bit pat_i [NPAT] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

  initial begin
    // ---------------- reset with both requests active ----------------
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    i_addr = 13'h0005; d_addr = 13'h0005; d_wdata = 16'hDEAD;
    @(negedge clk);
    chk("rst1_i_gnt", 32'(i_gnt), 32'd0);
    chk("rst1_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst1_mem_we", 32'(mem_we), 32'd0);
    chk("rst1_mem_re", 32'(mem_re), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rst2_gnts", {30'd0, i_gnt, d_gnt}, 32'd0);
    chk("rst2_mem", {30'd0, mem_we, mem_re}, 32'd0);
    next_cycle();
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalids", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    chk("post_rst_i_rdata", 32'(i_rdata), 32'h0000);
    chk("post_rst_d_rdata", 32'(d_rdata), 32'h0000);

    // ---------------- single fetch ----------------
    next_cycle();
    i_req = 1'b1; i_addr = 13'h0005;
    @(negedge clk);
    chk("fetch_i_gnt", 32'(i_gnt), 32'd1);
    chk("fetch_mem_re", 32'(mem_re), 32'd1);
    chk("fetch_mem_addr", 32'(mem_addr), 32'h0005);
    next_cycle();
    i_req = 1'b0;
    @(negedge clk);
    chk("fetch_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("fetch_i_rdata", 32'(i_rdata), 32'h1234);
    chk("fetch_d_rvalid", 32'(d_rvalid), 32'd0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("fetch_hold_rvalid", 32'(i_rvalid), 32'd0);
    chk("fetch_hold_rdata", 32'(i_rdata), 32'h1234);

    // ---------------- write then read at top address ----------------
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 13'h1FFF; d_wdata = 16'hBEEF;
    @(negedge clk);
    chk("wr_d_gnt", 32'(d_gnt), 32'd1);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_re", 32'(mem_re), 32'd0);
    chk("wr_mem_addr", 32'(mem_addr), 32'h1FFF);
    chk("wr_mem_data_in", 32'(mem_data_in), 32'hBEEF);
    next_cycle();
    d_we = 1'b0; d_wdata = 16'h0000;
    @(negedge clk);
    chk("rd_d_gnt", 32'(d_gnt), 32'd1);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    chk("rd_mem_re", 32'(mem_re), 32'd1);
    chk("wr_no_d_rvalid", 32'(d_rvalid), 32'd0);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    chk("rd_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("rd_d_rdata", 32'(d_rdata), 32'hBEEF);
    chk("rd_mem_we_idle", 32'(mem_we), 32'd0);
    chk("rd_i_rvalid", 32'(i_rvalid), 32'd0);

    // ---------------- contention pattern from a fresh reset ----------------
    next_cycle();
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 13'h0100; d_addr = 13'h0200;
    @(negedge clk);
    chk("cont_rst_gnts", {30'd0, i_gnt, d_gnt}, 32'd0);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < NPAT; k++) begin
      @(negedge clk);
      chk($sformatf("cont%0d_i_gnt", k), 32'(i_gnt), 32'(pat_i[k]));
      chk($sformatf("cont%0d_d_gnt", k), 32'(d_gnt), 32'(!pat_i[k]));
      if (k > 0) begin
        chk($sformatf("cont%0d_i_rvalid", k), 32'(i_rvalid), 32'(pat_i[k-1]));
        chk($sformatf("cont%0d_d_rvalid", k), 32'(d_rvalid), 32'(!pat_i[k-1]));
        if (pat_i[k-1]) chk($sformatf("cont%0d_i_rdata", k), 32'(i_rdata), 32'hA5A5);
        else            chk($sformatf("cont%0d_d_rdata", k), 32'(d_rdata), 32'h5A5A);
      end
      next_cycle();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("cont_tail_i_rvalid", 32'(i_rvalid), 32'(pat_i[NPAT-1]));
    chk("cont_tail_d_rvalid", 32'(d_rvalid), 32'(!pat_i[NPAT-1]));
    chk("cont_tail_i_rdata", 32'(i_rdata), 32'hA5A5);
    chk("cont_tail_d_rdata", 32'(d_rdata), 32'h5A5A);

    // ---------------- reset in the cycle after a fetch grant ----------------
    next_cycle();
    i_req = 1'b1; i_addr = 13'h0005;
    @(negedge clk);
    chk("rmid_i_gnt", 32'(i_gnt), 32'd1);
    next_cycle();
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    chk("rmid_n1_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rmid_n1_i_gnt", 32'(i_gnt), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rmid_n2_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rmid_n2_i_rdata", 32'(i_rdata), 32'h0000);
    chk("rmid_n2_d_rdata", 32'(d_rdata), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
